// File: rtl/booth_r4_seq_mul_pkg.sv
// booth_r4_seq_mul_pkg
//   Shared definitions for the iterative radix-4 Booth multiplier:
//   FSM state encoding, 3-bit Booth code constants and the default width.
//   No ports (package).
package booth_r4_seq_mul_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Booth triples {b[2k+1], b[2k], b[2k-1]}
  localparam logic [2:0] BOOTH_ZERO0 = 3'b000;
  localparam logic [2:0] BOOTH_POS1A = 3'b001;
  localparam logic [2:0] BOOTH_POS1B = 3'b010;
  localparam logic [2:0] BOOTH_POS2  = 3'b011;
  localparam logic [2:0] BOOTH_NEG2  = 3'b100;
  localparam logic [2:0] BOOTH_NEG1A = 3'b101;
  localparam logic [2:0] BOOTH_NEG1B = 3'b110;
  localparam logic [2:0] BOOTH_ZERO1 = 3'b111;

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// booth_r4_seq_mul_if
//   Request/response bundle for booth_r4_seq_mul.
//   start_i/a_i/b_i      : request (accepted when ready_o=1)
//   out_ready_i          : consumer accepts the product
//   ready_o/valid_o/busy_o/prod_o : multiplier status and result
//   master modport: requester/consumer side; slave modport: multiplier side.
interface booth_r4_seq_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 out_ready_i;
  logic                 ready_o;
  logic                 valid_o;
  logic                 busy_o;
  logic [2*WIDTH-1:0]   prod_o;

  modport master (
    output start_i, a_i, b_i, out_ready_i,
    input  ready_o, valid_o, busy_o, prod_o
  );

  modport slave (
    input  start_i, a_i, b_i, out_ready_i,
    output ready_o, valid_o, busy_o, prod_o
  );
endinterface

// File: rtl/booth_r4_seq_mul_enc.sv
// booth_r4_enc
//   Combinational radix-4 Booth partial-product selector.
//   a      : multiplicand (WIDTH, signed)
//   triple : Booth triple
//   pp     : selected partial product 0/+A/+2A/-A/-2A (WIDTH+1 bits, wraps
//            only for -2*(-2^(WIDTH-1)); the consumer restores that sign)
module booth_r4_enc
  import booth_r4_seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       triple,
  output logic [WIDTH:0]   pp
);
  logic [WIDTH:0] a_x1;
  logic [WIDTH:0] a_x2;

  always_comb begin
    a_x1 = {a[WIDTH-1], a};
    a_x2 = {a, 1'b0};
    pp   = '0;
    case (triple)
      BOOTH_POS1A, BOOTH_POS1B: pp = a_x1;
      BOOTH_POS2:               pp = a_x2;
      BOOTH_NEG2:               pp = -a_x2;
      BOOTH_NEG1A, BOOTH_NEG1B: pp = -a_x1;
      default:                  pp = '0;
    endcase
  end
endmodule

// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul
//   Iterative radix-4 Booth multiplier: one partial product per cycle,
//   WIDTH/2 CALC cycles, 2*WIDTH-bit signed product.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : start_i/a_i/b_i request, ready_o, busy_o,
//                   valid_o/prod_o result with out_ready_i acceptance
//   Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining
//   multiplier triples are all 000 or all 111.
module booth_r4_seq_mul
  import booth_r4_seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH/2)
) (
  input  logic              clk,
  input  logic              rst,
  booth_r4_seq_mul_if.slave bus
);
  localparam int unsigned LAST = WIDTH/2 - 1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH:0]       b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [2:0]           triple;
  logic [WIDTH:0]       pp;
  logic                 pp_sign;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   pp_sh;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;

  // b_q is arithmetically shifted right by two each CALC cycle, so the
  // current triple is always b_q[2:0] and b_q[WIDTH:2] holds the bits of
  // every later triple (sign-filled), equivalent to indexing by the counter.
  assign triple = b_q[2:0];

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .a      (a_q),
    .triple (triple),
    .pp     (pp)
  );

  always_comb begin
    // -2*A with A = -2^(WIDTH-1) is +2^WIDTH, which wraps in WIDTH+1 bits;
    // any -2*A of a negative A is non-negative, so force its sign to 0.
    pp_sign = pp[WIDTH] & ~((triple == BOOTH_NEG2) & a_q[WIDTH-1]);
    pp_ext  = {{(WIDTH-1){pp_sign}}, pp};
    pp_sh   = pp_ext << {cnt_q, 1'b0};
    acc_sum = acc_q + pp_sh;
`ifdef EARLY_TERM_EN
    last_iter = (cnt_q == CNT_W'(LAST)) || (&b_q[WIDTH:2]) || ~(|b_q[WIDTH:2]);
`else
    last_iter = (cnt_q == CNT_W'(LAST));
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = {bus.b_i, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        b_d   = {{2{b_q[WIDTH]}}, b_q[WIDTH:2]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          prod_d  = acc_sum;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.prod_o  = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
module tb_booth_r4_seq_mul;
  localparam int W = 32;

`ifdef EARLY_TERM_EN
  localparam int LAT = -1;
`else
  localparam int LAT = W/2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_r4_seq_mul_if #(.WIDTH(W)) bus ();
  booth_r4_seq_mul #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b1;
    while (!bus.valid_o) begin
      if (lat >= 40) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready_wait"}, bus.ready_o, 1);
  endtask

  // Issue one multiply, expect it back with out_ready_i held high.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p, input int exp_lat, input string name);
    int lat;
    bit ok;
    logic [2*W-1:0] e;
    wait_ready(name);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    exp_q.push_back(p);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    chk({name, " busy"}, bus.busy_o, 1);
    chk({name, " ready_low"}, bus.ready_o, 0);
    wait_valid(lat, ok);
    chk({name, " timeout"}, ok, 1);
    if (ok) begin
      if (exp_lat >= 0) chk({name, " latency"}, lat, exp_lat);
      if (exp_q.size() == 0) chk({name, " scoreboard_empty"}, 1, 0);
      else begin
        e = exp_q.pop_front();
        chk({name, " prod"}, bus.prod_o, e);
      end
      @(negedge clk);
      chk({name, " valid_drop"}, bus.valid_o, 0);
      chk({name, " ready_back"}, bus.ready_o, 1);
    end
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;
    logic [2*W-1:0] e;
    logic [W-1:0] ra, rb;

    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst ready", bus.ready_o, 1);
    chk("rst valid", bus.valid_o, 0);
    chk("rst busy",  bus.busy_o, 0);
    chk("rst prod",  bus.prod_o, 0);
    rst = 1'b0;

    vecs[0] = '{32'd3,        32'd5,        64'd15};
    vecs[1] = '{32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6};
    vecs[2] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1};
    vecs[6] = '{32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000};
    vecs[7] = '{32'd12345,    32'hFFFFFFFF, 64'hFFFFFFFF_FFFFCFC7};
    vecs[8] = '{32'd0,        32'hDEADBEEF, 64'd0};
    vecs[9] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000};

    for (int i = 0; i < 10; i++)
      do_mul(vecs[i].a, vecs[i].b, vecs[i].p, LAT, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_mul(ra, rb, model(ra, rb), LAT, $sformatf("rnd%0d", i));
    end

    // Backpressure with start pulses during CALC and DONE.
    bus.out_ready_i = 1'b0;
    wait_ready("bp");
    bus.start_i = 1'b1;
    bus.a_i     = 32'h00012345;
    bus.b_i     = 32'hFFFFFF00;
    exp_q.push_back(model(32'h00012345, 32'hFFFFFF00));
    @(negedge clk);
    bus.a_i = 32'h11111111;
    bus.b_i = 32'h22222222;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    wait_valid(lat, ok);
    chk("bp timeout", ok, 1);
    e = exp_q.pop_front();
    chk("bp prod", bus.prod_o, e);
    for (int i = 0; i < 5; i++) begin
      bus.start_i = i[0];
      @(negedge clk);
      chk($sformatf("bp hold_valid%0d", i), bus.valid_o, 1);
      chk($sformatf("bp hold_prod%0d", i), bus.prod_o, e);
      chk($sformatf("bp hold_ready%0d", i), bus.ready_o, 0);
    end
    bus.start_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp release_valid", bus.valid_o, 0);
    chk("bp release_ready", bus.ready_o, 1);
    chk("bp prod_held", bus.prod_o, e);
    repeat (2) @(negedge clk);
    chk("bp no_queued_start", bus.busy_o, 0);

    // Reset in the eighth CALC cycle.
    wait_ready("rst_mid");
    bus.start_i = 1'b1;
    bus.a_i     = 32'd5;
    bus.b_i     = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid busy_before", bus.busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid ready", bus.ready_o, 1);
    chk("rst_mid valid", bus.valid_o, 0);
    chk("rst_mid prod",  bus.prod_o, 0);
    chk("rst_mid busy",  bus.busy_o, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    chk("rst_mid no_valid", seen, 0);
    do_mul(32'd2, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFFA, LAT, "after_rst");

`ifdef EARLY_TERM_EN
    do_mul(32'h01234567, 32'd1,        64'h00000000_01234567, 1, "early_b1");
    do_mul(32'h01234567, 32'd0,        64'd0,                 1, "early_b0");
    do_mul(32'h01234567, 32'hFFFFFFFF, 64'hFFFFFFFF_FEDCBA99, 1, "early_bm1");
`else
    do_mul(32'h01234567, 32'd1,        64'h00000000_01234567, W/2, "fixed_b1");
    do_mul(32'h01234567, 32'hFFFFFFFF, 64'hFFFFFFFF_FEDCBA99, W/2, "fixed_bm1");
`endif

    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
